imm_extend_pipe: RTL and testbench

//  Registered, parametrised immediate generator for the ARMv8 datapath; successor of the combinational sign extender.

---
 rtl/imm_pkg.sv | 22 ++
 rtl/imm_bitmask_dec.sv | 52 +++++
 rtl/imm_extend_pipe.sv | 112 +++++++++++
 tb/tb_imm_extend_pipe.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared definitions for the ARMv8 immediate generator: extend-mode codes,
// the value driven on an invalid encoding, and the XLEN legality check.
package imm_pkg;

   localparam logic [3:0] IMM_I       = 4'd0;
   localparam logic [3:0] IMM_D       = 4'd1;
   localparam logic [3:0] IMM_B       = 4'd2;
   localparam logic [3:0] IMM_CB      = 4'd3;
   localparam logic [3:0] IMM_MOVZ0   = 4'd4;
   localparam logic [3:0] IMM_MOVZ1   = 4'd5;
   localparam logic [3:0] IMM_MOVZ2   = 4'd6;
   localparam logic [3:0] IMM_MOVZ3   = 4'd7;
   localparam logic [3:0] IMM_BITMASK = 4'd8;

   // Immediate value presented whenever the encoding is flagged invalid.
   localparam logic [63:0] IMM_ERR_VALUE = 64'd0;

   function automatic bit xlen_legal(input int xlen);
      return (xlen == 32) || (xlen == 64);
   endfunction

endpackage

// File: rtl/imm_bitmask_dec.sv
// Combinational decoder for logical bitmask immediates (N:immr:imms),
// producing the replicated XLEN-bit mask and an invalid-encoding flag.
module imm_bitmask_dec #(
   parameter int XLEN = 64
) (
   input  logic            n,
   input  logic [5:0]      immr,
   input  logic [5:0]      imms,
   output logic [XLEN-1:0] mask,
   output logic            invalid
);

   logic [6:0]  len_vec;
   logic [2:0]  len;
   logic        found;
   logic [5:0]  levels;
   logic [5:0]  s_val;
   logic [5:0]  r_val;
   logic [6:0]  esize;
   logic [63:0] welem;
   logic [63:0] emask;
   logic [63:0] rot;

   always_comb begin
      len_vec = {n, ~imms};
      len     = 3'd0;
      found   = 1'b0;
      for (int i = 0; i < 7; i++) begin
         if (len_vec[i]) begin
            len   = 3'(i);
            found = 1'b1;
         end
      end
      levels = 6'((7'd1 << len) - 7'd1);
      esize  = 7'd1 << len;
      s_val  = imms & levels;
      r_val  = immr & levels;
      welem  = (64'd1 << (7'(s_val) + 7'd1)) - 64'd1;
      emask  = (esize == 7'd64) ? '1 : ((64'd1 << esize) - 64'd1);
      // Rotate right within one element; welem never has bits above esize.
      rot    = ((welem >> r_val) | (welem << (esize - 7'(r_val)))) & emask;
      invalid = !found || (len == 3'd0) || (s_val == levels) || ((XLEN == 32) && n);
   end

   // Replication: bit gi of the result repeats element bit (gi mod esize).
   generate
      for (genvar gi = 0; gi < XLEN; gi++) begin : g_rep
         assign mask[gi] = rot[6'(gi) & levels];
      end
   endgenerate

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate generator: mode mux feeding an output register plus
// one skid entry on a valid/ready handshake, with sideband tag passthrough.
module imm_extend_pipe
   import imm_pkg::*;
#(
   parameter int XLEN  = 64,
   parameter int TAG_W = 5
) (
   input  logic             CLK,
   input  logic             resetl,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [25:0]      in_imm26,
   input  logic [3:0]       in_ctrl,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic             out_err,
   output logic [TAG_W-1:0] out_tag
);

   if (!xlen_legal(XLEN)) begin : g_xlen_bad
      $error("imm_extend_pipe: XLEN must be 32 or 64");
   end

   logic [XLEN-1:0]  bm_mask;
   logic             bm_invalid;
   logic [63:0]      wide;
   logic             res_err;
   logic [XLEN-1:0]  res_imm;

   logic             out_valid_reg, skid_valid_reg;
   logic [XLEN-1:0]  out_imm_reg, skid_imm_reg;
   logic             out_err_reg, skid_err_reg;
   logic [TAG_W-1:0] out_tag_reg, skid_tag_reg;
   logic             accept, load_out;

   imm_bitmask_dec #(.XLEN(XLEN)) u_bitmask (
      .n       (in_imm26[22]),
      .immr    (in_imm26[21:16]),
      .imms    (in_imm26[15:10]),
      .mask    (bm_mask),
      .invalid (bm_invalid)
   );

   always_comb begin
      wide    = 64'd0;
      res_err = 1'b0;
      case (in_ctrl)
         IMM_I:   wide = {52'd0, in_imm26[21:10]};
         IMM_D:   wide = {{55{in_imm26[20]}}, in_imm26[20:12]};
         IMM_B:   wide = {{36{in_imm26[25]}}, in_imm26, 2'b00};
         IMM_CB:  wide = {{43{in_imm26[23]}}, in_imm26[23:5], 2'b00};
         IMM_MOVZ0, IMM_MOVZ1, IMM_MOVZ2, IMM_MOVZ3: begin
            wide    = {48'd0, in_imm26[20:5]} << {in_ctrl[1:0], 4'b0000};
            res_err = (XLEN == 32) && in_ctrl[1];
         end
         IMM_BITMASK: begin
            wide[XLEN-1:0] = bm_mask;
            res_err        = bm_invalid;
         end
         default: res_err = 1'b1;
      endcase
      if (res_err) wide = IMM_ERR_VALUE;
      res_imm = wide[XLEN-1:0];
   end

   assign in_ready = !skid_valid_reg;
   assign accept   = in_valid && in_ready;
   assign load_out = !out_valid_reg || out_ready;

   always_ff @(posedge CLK or negedge resetl) begin
      if (!resetl) begin
         out_valid_reg  <= 1'b0;
         out_imm_reg    <= '0;
         out_err_reg    <= 1'b0;
         out_tag_reg    <= '0;
         skid_valid_reg <= 1'b0;
         skid_imm_reg   <= '0;
         skid_err_reg   <= 1'b0;
         skid_tag_reg   <= '0;
      end else if (load_out) begin
         // Skid holds the older entry, so it always has priority (and blocks accept).
         if (skid_valid_reg) begin
            out_valid_reg  <= 1'b1;
            out_imm_reg    <= skid_imm_reg;
            out_err_reg    <= skid_err_reg;
            out_tag_reg    <= skid_tag_reg;
            skid_valid_reg <= 1'b0;
         end else if (accept) begin
            out_valid_reg <= 1'b1;
            out_imm_reg   <= res_imm;
            out_err_reg   <= res_err;
            out_tag_reg   <= in_tag;
         end else begin
            out_valid_reg <= 1'b0;
         end
      end else if (accept) begin
         skid_valid_reg <= 1'b1;
         skid_imm_reg   <= res_imm;
         skid_err_reg   <= res_err;
         skid_tag_reg   <= in_tag;
      end
   end

   assign out_valid = out_valid_reg;
   assign out_imm   = out_imm_reg;
   assign out_err   = out_err_reg;
   assign out_tag   = out_tag_reg;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboard bench for imm_extend_pipe: XLEN=64 and XLEN=32 instances driven
// with directed vectors; forked monitors pop expectations on each output.
module tb_imm_extend_pipe;

   typedef struct {
      logic [63:0] imm;
      logic        err;
      logic [4:0]  tag;
   } exp_t;

   logic        CLK = 1'b0;
   logic        resetl;

   logic        iv64, rdy64, ov64, ordy64, oerr64;
   logic [25:0] imm64;
   logic [3:0]  ctrl64;
   logic [4:0]  tag64, otag64;
   logic [63:0] oimm64;

   logic        iv32, rdy32, ov32, ordy32, oerr32;
   logic [25:0] imm32;
   logic [3:0]  ctrl32;
   logic [4:0]  tag32, otag32;
   logic [31:0] oimm32;

   exp_t q64[$];
   exp_t q32[$];
   int   total = 0;
   int   bad   = 0;

   always #5 CLK = ~CLK;

   imm_extend_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
      .CLK(CLK), .resetl(resetl), .in_valid(iv64), .in_ready(rdy64),
      .in_imm26(imm64), .in_ctrl(ctrl64), .in_tag(tag64),
      .out_valid(ov64), .out_ready(ordy64), .out_imm(oimm64),
      .out_err(oerr64), .out_tag(otag64)
   );

   imm_extend_pipe #(.XLEN(32), .TAG_W(5)) dut32 (
      .CLK(CLK), .resetl(resetl), .in_valid(iv32), .in_ready(rdy32),
      .in_imm26(imm32), .in_ctrl(ctrl32), .in_tag(tag32),
      .out_valid(ov32), .out_ready(ordy32), .out_imm(oimm32),
      .out_err(oerr32), .out_tag(otag32)
   );

   initial begin
      #100000;
      $display("FAIL watchdog actual=still running required=finished");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic send64(input logic [25:0] imm, input logic [3:0] ctrl, input logic [4:0] tag,
                         input logic [63:0] exp_imm, input logic exp_err);
      exp_t e;
      int   waited = 0;
      iv64 = 1'b1; imm64 = imm; ctrl64 = ctrl; tag64 = tag;
      forever begin
         @(negedge CLK);
         if (rdy64) begin
            e.imm = exp_imm; e.err = exp_err; e.tag = tag;
            q64.push_back(e);
            @(posedge CLK); #1;
            break;
         end
         waited++;
         if (waited > 50) begin
            total++; bad++;
            $display("FAIL send64_timeout tag=%0d actual=not accepted required=accepted", tag);
            @(posedge CLK); #1;
            break;
         end
      end
      iv64 = 1'b0;
   endtask

   task automatic send32(input logic [25:0] imm, input logic [3:0] ctrl, input logic [4:0] tag,
                         input logic [63:0] exp_imm, input logic exp_err);
      exp_t e;
      int   waited = 0;
      iv32 = 1'b1; imm32 = imm; ctrl32 = ctrl; tag32 = tag;
      forever begin
         @(negedge CLK);
         if (rdy32) begin
            e.imm = exp_imm; e.err = exp_err; e.tag = tag;
            q32.push_back(e);
            @(posedge CLK); #1;
            break;
         end
         waited++;
         if (waited > 50) begin
            total++; bad++;
            $display("FAIL send32_timeout tag=%0d actual=not accepted required=accepted", tag);
            @(posedge CLK); #1;
            break;
         end
      end
      iv32 = 1'b0;
   endtask

   task automatic mon64();
      exp_t        e;
      logic        hv = 1'b0;
      logic [63:0] hi;
      logic        he;
      logic [4:0]  ht;
      forever begin
         @(negedge CLK);
         if (!resetl) begin
            hv = 1'b0;
         end else begin
            if (hv && ov64) begin
               total++;
               if ({oimm64, oerr64, otag64} !== {hi, he, ht}) begin
                  bad++;
                  $display("FAIL hold64 actual=%h/%b/%0d required=%h/%b/%0d", oimm64, oerr64, otag64, hi, he, ht);
               end
            end
            if (ov64 && ordy64) begin
               total++;
               if (q64.size() == 0) begin
                  bad++;
                  $display("FAIL unexpected64 actual=output tag=%0d required=no output", otag64);
               end else begin
                  e = q64.pop_front();
                  $display("dut64 txn tag=%0d imm=%h err=%b", otag64, oimm64, oerr64);
                  if (oimm64 !== e.imm || oerr64 !== e.err || otag64 !== e.tag) begin
                     bad++;
                     $display("FAIL result64 actual=%h/%b/%0d required=%h/%b/%0d", oimm64, oerr64, otag64, e.imm, e.err, e.tag);
                  end
               end
               hv = 1'b0;
            end else if (ov64) begin
               hv = 1'b1; hi = oimm64; he = oerr64; ht = otag64;
            end else begin
               hv = 1'b0;
            end
         end
      end
   endtask

   task automatic mon32();
      exp_t e;
      forever begin
         @(negedge CLK);
         if (resetl && ov32 && ordy32) begin
            total++;
            if (q32.size() == 0) begin
               bad++;
               $display("FAIL unexpected32 actual=output tag=%0d required=no output", otag32);
            end else begin
               e = q32.pop_front();
               $display("dut32 txn tag=%0d imm=%h err=%b", otag32, oimm32, oerr32);
               if ({32'd0, oimm32} !== e.imm || oerr32 !== e.err || otag32 !== e.tag) begin
                  bad++;
                  $display("FAIL result32 actual=%h/%b/%0d required=%h/%b/%0d", oimm32, oerr32, otag32, e.imm, e.err, e.tag);
               end
            end
         end
      end
   endtask

   initial begin
      resetl = 1'b0;
      iv64 = 1'b0; imm64 = '0; ctrl64 = '0; tag64 = '0; ordy64 = 1'b1;
      iv32 = 1'b0; imm32 = '0; ctrl32 = '0; tag32 = '0; ordy32 = 1'b1;
      fork
         mon64();
         mon32();
      join_none

      repeat (2) @(posedge CLK);
      #1;
      check("rst_out_valid", 64'(ov64), 64'd0);
      check("rst_in_ready", 64'(rdy64), 64'd1);
      check("rst_out_imm", oimm64, 64'd0);
      check("rst_out_err_tag", {58'd0, oerr64, otag64}, 64'd0);
      check("rst_in_ready32", 64'(rdy32), 64'd1);
      @(negedge CLK);
      resetl = 1'b1;
      @(posedge CLK); #1;

      // Branch sign extension with one-cycle latency.
      send64(26'h3FFFFFF, 4'd2, 5'd10, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
      @(negedge CLK);
      check("latency64", 64'(ov64), 64'd1);
      @(posedge CLK); #1;

      // Back-to-back stream with out_ready high.
      send64({3'd0, 1'b1, 6'd0, 6'h07, 10'd0}, 4'd8, 5'd11, 64'h0000_0000_0000_00FF, 1'b0);
      send64({3'd0, 1'b0, 6'd0, 6'h3C, 10'd0}, 4'd8, 5'd12, 64'h5555_5555_5555_5555, 1'b0);
      send64({3'd0, 1'b0, 6'd0, 6'h3D, 10'd0}, 4'd8, 5'd13, 64'd0, 1'b1);
      send64({3'd0, 1'b0, 6'd0, 6'h3E, 10'd0}, 4'd8, 5'd14, 64'd0, 1'b1);
      send64({3'd0, 1'b0, 6'd1, 6'b110010, 10'd0}, 4'd8, 5'd15, 64'h8383_8383_8383_8383, 1'b0);
      send64(26'h3FFFFFF, 4'd12, 5'd16, 64'd0, 1'b1);
      send64({4'd0, 12'hABC, 10'd0}, 4'd0, 5'd17, 64'h0000_0000_0000_0ABC, 1'b0);
      send64({5'd0, 9'h1F0, 12'd0}, 4'd1, 5'd18, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0);
      send64({2'd0, 19'h40000, 5'd0}, 4'd3, 5'd19, 64'hFFFF_FFFF_FFF0_0000, 1'b0);
      send64({5'd0, 16'hABCD, 5'd0}, 4'd7, 5'd20, 64'hABCD_0000_0000_0000, 1'b0);
      repeat (3) @(posedge CLK);
      #1;

      // Stall: two accepts fill output and skid, third waits for drain.
      ordy64 = 1'b0;
      send64({4'd0, 12'h001, 10'd0}, 4'd0, 5'd1, 64'h001, 1'b0);
      send64({4'd0, 12'h002, 10'd0}, 4'd0, 5'd2, 64'h002, 1'b0);
      @(negedge CLK);
      check("stall_in_ready", 64'(rdy64), 64'd0);
      fork
         send64({4'd0, 12'h003, 10'd0}, 4'd0, 5'd3, 64'h003, 1'b0);
         begin
            repeat (2) @(posedge CLK);
            #1 ordy64 = 1'b1;
         end
      join
      repeat (4) @(posedge CLK);
      #1;

      // XLEN=32 instance.
      send32({5'd0, 16'hABCD, 5'd0}, 4'd7, 5'd4, 64'd0, 1'b1);
      send32({5'd0, 16'hABCD, 5'd0}, 4'd5, 5'd5, 64'h0000_0000_ABCD_0000, 1'b0);
      send32({3'd0, 1'b1, 6'd0, 6'h07, 10'd0}, 4'd8, 5'd6, 64'd0, 1'b1);
      send32({3'd0, 1'b0, 6'd0, 6'h3C, 10'd0}, 4'd8, 5'd7, 64'h0000_0000_5555_5555, 1'b0);
      send32(26'h3FFFFFF, 4'd2, 5'd8, 64'h0000_0000_FFFF_FFFC, 1'b0);
      send32({5'd0, 9'h1F0, 12'd0}, 4'd1, 5'd9, 64'h0000_0000_FFFF_FFF0, 1'b0);
      repeat (3) @(posedge CLK);
      #1;

      // Asynchronous reset with output and skid both occupied.
      ordy64 = 1'b0;
      send64({4'd0, 12'h0AA, 10'd0}, 4'd0, 5'd21, 64'h0AA, 1'b0);
      send64({4'd0, 12'h0BB, 10'd0}, 4'd0, 5'd22, 64'h0BB, 1'b0);
      @(negedge CLK);
      check("pre_rst_full", {62'd0, ov64, rdy64}, 64'd2);
      #2 resetl = 1'b0;
      #1;
      check("arst_out_valid", 64'(ov64), 64'd0);
      check("arst_in_ready", 64'(rdy64), 64'd1);
      check("arst_out_imm", oimm64, 64'd0);
      check("arst_out_err_tag", {58'd0, oerr64, otag64}, 64'd0);
      q64.delete();
      ordy64 = 1'b1;
      @(negedge CLK);
      resetl = 1'b1;
      repeat (5) @(posedge CLK);
      #1;
      check("post_rst_quiet", 64'(ov64), 64'd0);

      check("q64_empty", 64'(q64.size()), 64'd0);
      check("q32_empty", 64'(q32.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
